// File: rtl/buffer_arbiter_if.sv
// Bundle between the input buffers, the arbiter and the output link.
// The slave view is the arbiter; the master view is whatever owns the buffers and the link.
interface buffer_arbiter_if #(
  parameter int num_ports    = 4,
  parameter int buffer_width = 64
);
  logic [num_ports-1:0]              empty;
  logic [num_ports*buffer_width-1:0] in_data;
  logic [num_ports-1:0]              consume;
  logic                              credit_in;
  logic [buffer_width-1:0]           out_data;
  logic                              out_valid;
  logic [num_ports-1:0]              grant;

  modport master (
    output empty, in_data, credit_in,
    input  consume, out_data, out_valid, grant
  );

  modport slave (
    input  empty, in_data, credit_in,
    output consume, out_data, out_valid, grant
  );
endinterface

// File: rtl/buffer_arbiter.sv
// Round-robin, packet-locked arbiter that moves flits from several input buffers
// onto one credit-controlled output link. A packet owns the link from its grant
// until its tail flit has been forwarded.
module buffer_arbiter #(
  parameter int num_ports    = 4,
  parameter int buffer_width = 64,
  parameter int credit_max   = 8
) (
  input logic             clk,
  input logic             rst,
  buffer_arbiter_if.slave bus
);
  localparam int pw = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int cw = $clog2(credit_max + 1);
  localparam logic [pw-1:0] last_port   = pw'(num_ports - 1);
  localparam logic [cw-1:0] credit_full = cw'(credit_max);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state_reg, state_next;
  logic [num_ports-1:0]    grant_reg, grant_next;
  logic [pw-1:0]           last_grant_reg, last_grant_next;
  logic [cw-1:0]           credit_reg, credit_next;
  logic                    out_valid_reg;

  logic [num_ports-1:0]    consume_sel;
  logic                    any_consume;
  logic                    have_credit;
  logic                    tail_seen;
  logic [buffer_width-1:0] slice_data [num_ports];
  logic [buffer_width-1:0] out_data_mux;

  logic                    rr_found;
  logic [pw-1:0]           rr_index;
  logic [pw-1:0]           rr_cand;
  logic [num_ports-1:0]    rr_onehot;

  // Split the flat input bus into one word per buffer.
  for (genvar gi = 0; gi < num_ports; gi++) begin : g_slice
    assign slice_data[gi] = bus.in_data[gi*buffer_width +: buffer_width];
  end

  // Output word follows the granted buffer directly; nothing granted gives zero.
  always_comb begin
    out_data_mux = '0;
    for (int i = 0; i < num_ports; i++) begin
      if (grant_reg[i]) begin
        out_data_mux = out_data_mux | slice_data[i];
      end
    end
  end

  assign have_credit = (credit_reg != '0);
  assign tail_seen   = out_valid_reg && out_data_mux[buffer_width-1];

  // Round-robin search starting just after the previous owner, wrapping to port 0.
  always_comb begin
    rr_found  = 1'b0;
    rr_index  = last_grant_reg;
    rr_cand   = '0;
    rr_onehot = '0;
    for (int k = 1; k <= num_ports; k++) begin
      rr_cand = pw'((int'(last_grant_reg) + k) % num_ports);
      if (!rr_found && !bus.empty[rr_cand]) begin
        rr_found = 1'b1;
        rr_index = rr_cand;
      end
    end
    rr_onehot[rr_index] = rr_found;
  end

  // Next state, grant and read strobes. Once the tail is on the link no further
  // read is issued, so the following packet in the same buffer waits for a new grant.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    consume_sel     = '0;
    case (state_reg)
      IDLE: begin
        if (have_credit && rr_found) begin
          grant_next      = rr_onehot;
          last_grant_next = rr_index;
          state_next      = LOCK;
        end
      end
      LOCK: begin
        if (tail_seen) begin
          grant_next = '0;
          state_next = IDLE;
        end else if (have_credit) begin
          consume_sel = grant_reg & ~bus.empty;
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
    // No buffer is popped while in reset, so an interrupted flit is never lost in flight.
    if (!rst) begin
      consume_sel = '0;
    end
  end

  assign any_consume = |consume_sel;

  // Credit accounting: a read spends a slot, a returned credit refunds one, both cancel.
  always_comb begin
    credit_next = credit_reg;
    if (any_consume && !bus.credit_in) begin
      credit_next = credit_reg - cw'(1);
    end else if (!any_consume && bus.credit_in && (credit_reg != credit_full)) begin
      credit_next = credit_reg + cw'(1);
    end
  end

  // Arbitration state register; last owner resets to the highest port so port 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= last_port;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Credit counter and the one-cycle buffer read latency for out_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_reg    <= credit_full;
      out_valid_reg <= 1'b0;
    end else begin
      credit_reg    <= credit_next;
      out_valid_reg <= any_consume;
    end
  end

  assign bus.consume   = consume_sel;
  assign bus.grant     = grant_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_mux;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: a buffer model feeds the active DUT, a scoreboard
// checks every forwarded flit, and each scenario checks grant/consume timing.
`timescale 1ns/1ps
module tb_buffer_arbiter;
  localparam int np = 4;
  localparam int bw = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  buffer_arbiter_if #(.num_ports(np), .buffer_width(bw)) bus_a ();
  buffer_arbiter_if #(.num_ports(np), .buffer_width(bw)) bus_b ();

  buffer_arbiter #(.num_ports(np), .buffer_width(bw), .credit_max(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  buffer_arbiter #(.num_ports(np), .buffer_width(bw), .credit_max(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit sel = 1'b0;              // 0: dut_a active, 1: dut_b active
  logic credit_in_m = 1'b0;

  logic [bw-1:0] fifo_q [np][$];
  logic [bw-1:0] out_word [np];
  logic [bw-1:0] exp_q [$];

  logic [np-1:0] cons_s, grant_s;
  logic          ov_s;
  logic [bw-1:0] od_s;

  function automatic logic [bw-1:0] mk(int port, int seq, bit tail);
    logic [bw-1:0] v;
    v = {$urandom, $urandom};
    v[bw-1] = tail;
    v[15:8] = port[7:0];
    v[7:0]  = seq[7:0];
    return v;
  endfunction

  task automatic drive();
    logic [np-1:0]    emp;
    logic [np*bw-1:0] dat;
    for (int i = 0; i < np; i++) begin
      emp[i] = (fifo_q[i].size() == 0);
      dat[i*bw +: bw] = out_word[i];
    end
    if (!sel) begin
      bus_a.empty = emp;  bus_a.in_data = dat;  bus_a.credit_in = credit_in_m;
      bus_b.empty = '1;   bus_b.in_data = '0;   bus_b.credit_in = 1'b0;
    end else begin
      bus_b.empty = emp;  bus_b.in_data = dat;  bus_b.credit_in = credit_in_m;
      bus_a.empty = '1;   bus_a.in_data = '0;   bus_a.credit_in = 1'b0;
    end
  endtask

  task automatic push(int port, int n);
    for (int s = 0; s < n; s++) fifo_q[port].push_back(mk(port, s, s == n - 1));
    drive();
  endtask

  // One clock: sample at negedge, score output, then pop model buffers after the edge.
  task automatic step();
    logic [bw-1:0] e;
    @(negedge clk);
    if (!sel) begin
      cons_s = bus_a.consume; grant_s = bus_a.grant; ov_s = bus_a.out_valid; od_s = bus_a.out_data;
    end else begin
      cons_s = bus_b.consume; grant_s = bus_b.grant; ov_s = bus_b.out_valid; od_s = bus_b.out_data;
    end
    if (exp_q.size() > 0 || ov_s) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d got out_valid=1 data=%h required no flit", cyc, od_s);
      end else begin
        e = exp_q.pop_front();
        if (ov_s !== 1'b1 || od_s !== e) begin
          errors++;
          $display("FAIL sb_flit cyc=%0d got valid=%0b data=%h required valid=1 data=%h", cyc, ov_s, od_s, e);
        end else begin
          $display("flit cyc=%0d data=%h", cyc, od_s);
        end
      end
    end
    if (cons_s !== '0) begin
      checks++;
      if ($countones(cons_s) != 1) begin
        errors++;
        $display("FAIL consume_onehot cyc=%0d got %b required one bit", cyc, cons_s);
      end
      for (int i = 0; i < np; i++) begin
        if (cons_s[i]) begin
          if (fifo_q[i].size() == 0) begin
            errors++;
            $display("FAIL consume_empty cyc=%0d got consume[%0d]=1 required 0 (buffer empty)", cyc, i);
          end else begin
            exp_q.push_back(fifo_q[i][0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < np; i++) begin
      if (cons_s[i] && fifo_q[i].size() > 0) out_word[i] = fifo_q[i].pop_front();
    end
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    credit_in_m = 1'b0;
    drive();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (cons_s !== '0) begin
        errors++;
        $display("FAIL reset_consume got %b required 0000", cons_s);
      end
    end
    for (int i = 0; i < np; i++) begin
      fifo_q[i].delete();
      out_word[i] = '0;
    end
    exp_q.delete();
    rst = 1'b1;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    step();
    checks += 5;
    if (grant_s !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b required 0000", grant_s); end
    if (ov_s !== 1'b0)       begin errors++; $display("FAIL rst_out_valid got %b required 0", ov_s); end
    if (cons_s !== 4'b0000)  begin errors++; $display("FAIL rst_consume got %b required 0000", cons_s); end
    if (od_s !== '0)         begin errors++; $display("FAIL rst_out_data got %h required 0", od_s); end
    if (dut_a.credit_reg !== 4'd8) begin errors++; $display("FAIL rst_credits got %0d required 8", dut_a.credit_reg); end
  endtask

  task automatic test_single_packet();
    int eg [6] = '{0, 4, 4, 4, 4, 0};
    int ec [6] = '{0, 4, 4, 4, 0, 0};
    int eo [6] = '{0, 0, 1, 1, 1, 0};
    sel = 1'b0;
    do_reset();
    push(2, 3);
    for (int c = 0; c < 6; c++) begin
      step();
      checks += 3;
      if (grant_s !== np'(eg[c])) begin errors++; $display("FAIL single_grant c=%0d got %b required %b", c, grant_s, np'(eg[c])); end
      if (cons_s !== np'(ec[c]))  begin errors++; $display("FAIL single_consume c=%0d got %b required %b", c, cons_s, np'(ec[c])); end
      if (ov_s !== 1'(eo[c]))     begin errors++; $display("FAIL single_valid c=%0d got %b required %b", c, ov_s, 1'(eo[c])); end
    end
    checks++;
    if (dut_a.credit_reg !== 4'd5) begin errors++; $display("FAIL single_credits got %0d required 5", dut_a.credit_reg); end
  endtask

  task automatic test_round_robin();
    logic [np-1:0] eg, ec;
    sel = 1'b0;
    do_reset();
    for (int p = 0; p < np; p++) begin
      push(p, 1);
      push(p, 1);
    end
    for (int c = 0; c < 15; c++) begin
      step();
      eg = (c % 3 == 0) ? '0 : np'(1 << ((c / 3) % np));
      ec = (c % 3 == 1) ? eg : '0;
      checks += 3;
      if (grant_s !== eg)        begin errors++; $display("FAIL rr_grant c=%0d got %b required %b", c, grant_s, eg); end
      if (cons_s !== ec)         begin errors++; $display("FAIL rr_consume c=%0d got %b required %b", c, cons_s, ec); end
      if (ov_s !== (c % 3 == 2)) begin errors++; $display("FAIL rr_valid c=%0d got %b required %b", c, ov_s, (c % 3 == 2)); end
    end
  endtask

  task automatic test_credit_stall();
    int eg [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ec [14] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    int eo [14] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    sel = 1'b1;
    do_reset();
    push(0, 4);
    for (int c = 0; c < 14; c++) begin
      credit_in_m = (c == 7 || c == 10);
      drive();
      step();
      checks += 3;
      if (grant_s !== np'(eg[c])) begin errors++; $display("FAIL stall_grant c=%0d got %b required %b", c, grant_s, np'(eg[c])); end
      if (cons_s !== np'(ec[c]))  begin errors++; $display("FAIL stall_consume c=%0d got %b required %b", c, cons_s, np'(ec[c])); end
      if (ov_s !== 1'(eo[c]))     begin errors++; $display("FAIL stall_valid c=%0d got %b required %b", c, ov_s, 1'(eo[c])); end
      if (c == 5) begin
        checks++;
        if (dut_b.credit_reg !== 2'd0) begin errors++; $display("FAIL stall_credits got %0d required 0", dut_b.credit_reg); end
      end
    end
    credit_in_m = 1'b0;
    drive();
  endtask

  task automatic test_no_interleave();
    int eg [13] = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 0, 8, 8, 0};
    int ec [13] = '{0, 2, 0, 0, 0, 0, 0, 2, 0, 0, 8, 0, 0};
    int eo [13] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    sel = 1'b0;
    do_reset();
    fifo_q[1].push_back(mk(1, 0, 1'b0));
    push(3, 1);
    for (int c = 0; c < 13; c++) begin
      if (c == 7) begin
        fifo_q[1].push_back(mk(1, 1, 1'b1));
        drive();
      end
      step();
      checks += 3;
      if (grant_s !== np'(eg[c])) begin errors++; $display("FAIL hold_grant c=%0d got %b required %b", c, grant_s, np'(eg[c])); end
      if (cons_s !== np'(ec[c]))  begin errors++; $display("FAIL hold_consume c=%0d got %b required %b", c, cons_s, np'(ec[c])); end
      if (ov_s !== 1'(eo[c]))     begin errors++; $display("FAIL hold_valid c=%0d got %b required %b", c, ov_s, 1'(eo[c])); end
    end
  endtask

  task automatic test_credit_edge();
    int ecr [6] = '{2, 1, 1, 0, 0, 0};
    int ec  [6] = '{0, 1, 1, 1, 0, 0};
    sel = 1'b0;
    do_reset();
    credit_in_m = 1'b1;
    drive();
    step();
    credit_in_m = 1'b0;
    drive();
    step();
    checks++;
    if (dut_a.credit_reg !== 4'd8) begin errors++; $display("FAIL credit_sat got %0d required 8", dut_a.credit_reg); end
    sel = 1'b1;
    do_reset();
    push(0, 3);
    for (int c = 0; c < 6; c++) begin
      credit_in_m = (c == 2);
      drive();
      step();
      checks += 2;
      if (cons_s !== np'(ec[c])) begin errors++; $display("FAIL credit_consume c=%0d got %b required %b", c, cons_s, np'(ec[c])); end
      if (dut_b.credit_reg !== 2'(ecr[c])) begin
        errors++;
        $display("FAIL credit_count c=%0d got %0d required %0d", c, dut_b.credit_reg, ecr[c]);
      end
    end
    credit_in_m = 1'b0;
    drive();
  endtask

  task automatic test_reset_midpacket();
    sel = 1'b0;
    do_reset();
    push(1, 3);
    step();                              // c0: IDLE, port 1 granted
    step();                              // c1: first flit consumed
    rst = 1'b0;
    push(0, 1);
    push(3, 1);
    step();                              // c2: reset on the second flit
    checks++;
    if (cons_s !== 4'b0000) begin errors++; $display("FAIL midrst_consume got %b required 0000", cons_s); end
    rst = 1'b1;
    drive();
    step();                              // c3
    checks += 3;
    if (ov_s !== 1'b0)       begin errors++; $display("FAIL midrst_valid got %b required 0", ov_s); end
    if (grant_s !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b required 0000", grant_s); end
    if (dut_a.credit_reg !== 4'd8) begin errors++; $display("FAIL midrst_credits got %0d required 8", dut_a.credit_reg); end
    for (int c = 4; c < 14; c++) begin
      step();
      if (c == 4 || c == 7 || c == 11) begin
        checks++;
        if (grant_s !== np'(c == 4 ? 1 : (c == 7 ? 2 : 8))) begin
          errors++;
          $display("FAIL midrst_order c=%0d got %b required %b", c, grant_s, np'(c == 4 ? 1 : (c == 7 ? 2 : 8)));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || fifo_q[0].size() != 0 || fifo_q[1].size() != 0 || fifo_q[3].size() != 0) begin
      errors++;
      $display("FAIL midrst_drain got pending=%0d p1_left=%0d required 0 and 0", exp_q.size(), fifo_q[1].size());
    end
  endtask

  initial begin
    drive();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_stall();
    test_no_interleave();
    test_credit_edge();
    test_reset_midpacket();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish required finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 SHALL have parameter num_ports, default 4, meaning number of input buffers sharing one output link.
REQ-002 SHALL have parameter buffer_width, default 64, meaning flit width; bit buffer_width-1 is the tail flag.
REQ-003 SHALL have parameter credit_max, default 8, meaning downstream buffer slots available after reset.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-low (0 = reset, sampled on posedge clk).
REQ-006 SHALL have port empty, input, num_ports, meaning per-buffer empty flags.
REQ-007 SHALL have port in_data, input, num_ports*buffer_width, meaning per-buffer registered out words; port i occupies slice i.
REQ-008 SHALL have port consume, output, num_ports, meaning per-buffer read strobes, at most one bit set.
REQ-009 SHALL have port credit_in, input, 1, meaning one downstream slot freed this cycle.
REQ-010 SHALL have port out_data, output, buffer_width, meaning the flit forwarded to the output link.
REQ-011 SHALL have port out_valid, output, 1, meaning out_data is valid this cycle.
REQ-012 SHALL have port grant, output, num_ports, meaning one-hot owner of the link; all zero when idle.

Function
REQ-013 SHALL implement two states: IDLE, LOCK.
REQ-014 IDLE: if credits>0 and any empty[i]==0, SHALL select the first non-empty port searching round-robin from last_grant+1 (wrapping at num_ports-1 to 0), register grant, update last_grant, and enter LOCK next cycle; consume stays 0 in IDLE.
REQ-015 LOCK: consume[g] SHALL be asserted combinationally when empty[g]==0, credits>0, and not (out_valid and out_data tail bit set); all other consume bits 0.
REQ-016 Buffer read latency is 1 cycle: out_valid SHALL be consume[g] registered by one cycle; out_data SHALL be in_data slice g, combinational from grant.
REQ-017 When out_valid==1 and out tail bit==1 in LOCK, SHALL return to IDLE next cycle, clearing grant; no consume issued in that cycle.
REQ-018 Credit counter, width clog2(credit_max+1): -1 on consume of any port, +1 on credit_in, unchanged when both occur; SHALL never exceed credit_max nor go below 0 (credit_in at credit_max ignored).
REQ-019 credits==0 SHALL stall consume while holding LOCK; the packet resumes when credit returns.
REQ-020 A granted port going empty mid-packet SHALL hold LOCK (no interleaving) until its tail is forwarded.
REQ-021 Single-flit packet (head==tail): 1 consume, out_valid 1 cycle later, back to IDLE the next cycle.

Reset
REQ-022 While rst==0 on a posedge: state=IDLE, grant=0, last_grant=num_ports-1 (port 0 highest priority first), credits=credit_max, out_valid=0, out_data=0, consume=0.
REQ-023 Reset asserted mid-packet SHALL abandon the packet; the flit from a same-cycle consume SHALL not appear on out_valid.

Verification
REQ-024 Reset, then port 2 non-empty with 3-flit packet -> grant=0100 after 1 cycle, consume[2] 3 consecutive cycles, out_valid 3 cycles lagging by 1, tail on 3rd, grant=0 next cycle, credits=5.
REQ-025 All 4 ports hold 1-flit packets continuously -> grant order 0,1,2,3,0, each 3 cycles (IDLE, consume, tail).
REQ-026 credit_max=2, 4-flit packet on port 0, no credit_in -> 2 flits out, consume held 0, grant stays 0001; credit_in pulse -> 3rd flit resumes.
REQ-027 Port 1 empties after head flit for 5 cycles while port 3 is non-empty -> grant stays 0010, port 3 untouched until port 1 tail forwarded.
REQ-028 credit_in coincident with consume at credits=1 -> credits stays 1; credit_in at credits=credit_max -> stays credit_max.
REQ-029 rst=0 asserted on 2nd flit of a packet -> next cycle out_valid=0, grant=0, credits=credit_max, arbitration restarts from port 0.
